disp_fifo_rd: RTL and testbench
===============================

Name: disp_fifo_rd

Overview:
Display-side consumer of the 125→25 MHz pixel FIFO. The frame-buffer read logic fills that FIFO. This block pops it through a 2-entry prefetch buffer and presents one pixel per active display cycle. It also drives the display-request line back to the frame-buffer side. It runs entirely in the display (pixel) clock domain.

Parameters:
DATA_WIDTH, 12, pixel width (RGB444).
FRAME_PIXELS, 307200, active pixels per frame (640x480).
UNDERFLOW_COLOR, 12'hF00, pixel emitted when no data is buffered during active video (DATA_WIDTH bits).

Ports:
i_clk  in  1  display pixel clock (25 MHz)
i_rstn  in  1  asynchronous active-low reset
o_rd  out  1  FIFO read enable
i_rdata  in  DATA_WIDTH  FIFO read data, valid the cycle after o_rd
i_empty  in  1  FIFO empty flag
i_frame_start  in  1  one-cycle pulse at start of frame (vertical blanking)
i_active  in  1  display active-video window
o_req  out  1  display request to frame-buffer read side
o_pixel  out  DATA_WIDTH  registered pixel output
o_pixel_valid  out  1  registered; i_active delayed by one cycle
o_underflow  out  1  sticky underflow flag
o_pix_count  out  19  pixel index within current frame

Behaviour:
- Reset (async assert, sync release): state=IDLE. The following are all 0: o_rd, o_req, o_pixel, o_pixel_valid, o_underflow, o_pix_count, buffer occupancy, read-pending.
- Prefetch buffer:
  - 2 entries, head first. occ is 0..2. pend=1 when o_rd was asserted last cycle.
  - o_rd is combinational: !i_empty && state!=IDLE && (occ + pend − consume) < 2. consume = i_active && occ>0 && state==STREAM.
  - When pend=1, i_rdata is written into the buffer at the next free slot after any same-cycle consume.
  - The buffer never overflows. Consume and fill in the same cycle keeps occ unchanged.
- States:
  - IDLE: no reads. o_req=0. Goes to FILL on i_frame_start.
  - FILL: o_req=1, prefetching. Goes to STREAM when occ==2 (registered transition). If i_active goes high in FILL, the block emits UNDERFLOW_COLOR, sets o_underflow, and increments o_pix_count. It does not consume.
  - STREAM: o_req=1.
    - Each i_active cycle advances o_pix_count.
    - If occ>0: o_pixel<=head and the head is popped.
    - If occ==0: o_pixel<=UNDERFLOW_COLOR and o_underflow<=1. The counter still advances to keep frame alignment.
    - When an active cycle occurs with o_pix_count==FRAME_PIXELS−1, o_pix_count wraps to 0 and the state goes to DONE.
  - DONE: o_req=1 and prefetch continues (buffer refills to 2). i_active cycles output 0, do not consume, and do not flag. Goes to FILL on i_frame_start.
- i_frame_start in FILL or STREAM (early/mid-frame): o_pix_count<=0 and the state goes to FILL. The buffer is not flushed. o_underflow is unaffected.
- i_frame_start and i_active in the same cycle: frame_start is applied first. The active cycle counts as pixel 0 of the new frame and follows FILL rules.
- Latency: 1 cycle from i_active to o_pixel/o_pixel_valid. o_pixel holds its last value when inactive.
- o_underflow clears only on reset.
- o_pix_count is 19-bit unsigned and never exceeds FRAME_PIXELS−1.
- Reset asserted mid-stream: all state clears immediately. An in-flight FIFO word is dropped.

Optional Feature:
UNDERFLOW_CNT_EN:
- Defined: adds output o_underflow_cnt [15:0]. It increments on each underflow pixel, saturates at 16'hFFFF, and resets to 0 on reset only.
- Undefined: the port and counter are absent. o_underflow is the only indication.

Test Plan:
- Reset then i_frame_start with FIFO preloaded with 0x001,0x002,0x003 → o_rd high on 2 cycles, occ=2, state STREAM. Then i_active for 3 cycles → o_pixel 0x001,0x002,0x003 each one cycle after the active cycle, with o_pixel_valid high; o_underflow=0.
- FIFO empty during active in STREAM → o_pixel=0xF00, o_underflow=1 and stays 1. o_pix_count still increments. With UNDERFLOW_CNT_EN, o_underflow_cnt=number of empty active cycles.
- FRAME_PIXELS=16, continuously non-empty FIFO, 20 active cycles → pixels 0..15 consumed, o_pix_count wraps to 0, state DONE. The last 4 outputs are 0 with no pops beyond the buffer refill.
- i_frame_start at pixel 5 of a frame → o_pix_count=0 next cycle, state FILL, buffered pixels retained and emitted first.
- Simultaneous consume and FIFO return with occ=2 → occ stays 2, pixel order preserved, no lost or duplicated word (checked with an incrementing data pattern).
- Assert i_rstn low mid-STREAM asynchronously → all outputs 0 before the next clock edge. After release, no o_rd until i_frame_start.

Source files
------------

// File: rtl/disp_fifo_rd.sv
// disp_fifo_rd: display-side consumer of the pixel FIFO.
// The block pops the FIFO into a 2-entry prefetch buffer and emits one pixel
// per active-video cycle, one cycle after i_active. If no pixel is buffered
// during active video, it emits UNDERFLOW_COLOR.
// The block runs entirely in the pixel clock domain.
//
// Ports:
//   i_clk, i_rstn      pixel clock, async active-low reset
//   o_rd               FIFO pop (combinational); i_rdata valid next cycle
//   i_rdata, i_empty   FIFO read data / empty flag
//   i_frame_start      1-cycle frame start pulse
//   i_active           active-video window
//   o_req              request to frame-buffer read side
//   o_pixel            registered pixel output
//   o_pixel_valid      registered i_active
//   o_underflow        sticky underflow flag
//   o_pix_count        pixel index within current frame
//   o_underflow_cnt    saturating underflow pixel count
//                      (only when UNDERFLOW_CNT_EN is defined)
//
// Optional feature macro: UNDERFLOW_CNT_EN
module disp_fifo_rd #(
    parameter int                    DATA_WIDTH      = 12,
    parameter int                    FRAME_PIXELS    = 307200,
    parameter logic [DATA_WIDTH-1:0] UNDERFLOW_COLOR = 12'hF00
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    output logic                  o_rd,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  i_empty,
    input  logic                  i_frame_start,
    input  logic                  i_active,
    output logic                  o_req,
    output logic [DATA_WIDTH-1:0] o_pixel,
    output logic                  o_pixel_valid,
    output logic                  o_underflow,
`ifdef UNDERFLOW_CNT_EN
    output logic [15:0]           o_underflow_cnt,
`endif
    output logic [18:0]           o_pix_count
);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    localparam logic [18:0] LAST_PIX = 19'(FRAME_PIXELS - 1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic [1:0]            r_occ;
    logic                  r_pend;

    state_t                w_st;
    logic                  w_consume;
    logic [1:0]            w_occ_c;
    logic [2:0]            w_level;
    logic [18:0]           w_cnt_base;
    logic [18:0]           w_cnt_inc;

    // A frame start takes effect before a same-cycle active pixel, so that
    // pixel is handled under FILL rules as pixel 0 of the new frame.
    assign w_st       = i_frame_start ? FILL : r_state;
    assign w_consume  = i_active && (r_occ != 2'd0) && (w_st == STREAM);
    assign w_occ_c    = r_occ - {1'b0, w_consume};
    // Words held plus the word in flight, after this cycle's pop.
    assign w_level    = {1'b0, r_occ} + {2'b0, r_pend} - {2'b0, w_consume};
    assign o_rd       = !i_empty && (r_state != IDLE) && (w_level < 3'd2);
    assign w_cnt_base = i_frame_start ? 19'd0 : o_pix_count;
    assign w_cnt_inc  = (w_cnt_base == LAST_PIX) ? 19'd0 : w_cnt_base + 19'd1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state         <= IDLE;
            r_buf[0]        <= '0;
            r_buf[1]        <= '0;
            r_occ           <= 2'd0;
            r_pend          <= 1'b0;
            o_req           <= 1'b0;
            o_pixel         <= '0;
            o_pixel_valid   <= 1'b0;
            o_underflow     <= 1'b0;
            o_pix_count     <= 19'd0;
`ifdef UNDERFLOW_CNT_EN
            o_underflow_cnt <= 16'd0;
`endif
        end else begin
            r_pend        <= o_rd;
            o_pixel_valid <= i_active;
            // The state only leaves IDLE, and never returns to it.
            o_req         <= (w_st != IDLE);
            r_state       <= w_st;
            o_pix_count   <= w_cnt_base;

            // Pop shifts the tail forward. A returning word lands in the
            // first free slot after the pop. The later write wins when both
            // target slot 0.
            if (w_consume) r_buf[0] <= r_buf[1];
            if (r_pend)    r_buf[w_occ_c[0]] <= i_rdata;
            r_occ <= w_occ_c + {1'b0, r_pend};

            case (w_st)
                FILL: begin
                    if (!i_frame_start && r_occ == 2'd2) r_state <= STREAM;
                    if (i_active) begin
                        o_pixel     <= UNDERFLOW_COLOR;
                        o_underflow <= 1'b1;
                        o_pix_count <= w_cnt_inc;
`ifdef UNDERFLOW_CNT_EN
                        if (o_underflow_cnt != 16'hFFFF)
                            o_underflow_cnt <= o_underflow_cnt + 16'd1;
`endif
                    end
                end
                STREAM: begin
                    if (i_active) begin
                        o_pix_count <= w_cnt_inc;
                        if (w_consume) begin
                            o_pixel <= r_buf[0];
                        end else begin
                            o_pixel     <= UNDERFLOW_COLOR;
                            o_underflow <= 1'b1;
`ifdef UNDERFLOW_CNT_EN
                            if (o_underflow_cnt != 16'hFFFF)
                                o_underflow_cnt <= o_underflow_cnt + 16'd1;
`endif
                        end
                        if (w_cnt_base == LAST_PIX) r_state <= DONE;
                    end
                end
                DONE: begin
                    if (i_active) o_pixel <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_fifo_rd.sv
// Bench for disp_fifo_rd (small frame). Uses a queue-based FIFO, and a
// queue-based behavioural model of the prefetch/frame rules.
module tb_disp_fifo_rd;
    localparam int DW = 12;
    localparam int FP = 16;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          o_rd;
    logic [DW-1:0] i_rdata = '0;
    logic          i_empty = 1'b1;
    logic          i_frame_start = 1'b0;
    logic          i_active = 1'b0;
    logic          o_req;
    logic [DW-1:0] o_pixel;
    logic          o_pixel_valid;
    logic          o_underflow;
    logic [18:0]   o_pix_count;

    always #5 i_clk = ~i_clk;

    disp_fifo_rd #(.DATA_WIDTH(DW), .FRAME_PIXELS(FP), .UNDERFLOW_COLOR(12'hF00)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .o_rd(o_rd), .i_rdata(i_rdata),
        .i_empty(i_empty), .i_frame_start(i_frame_start), .i_active(i_active),
        .o_req(o_req), .o_pixel(o_pixel), .o_pixel_valid(o_pixel_valid),
        .o_underflow(o_underflow), .o_pix_count(o_pix_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] fifo [$];
    logic [DW-1:0] seq = '0;

    typedef enum {M_IDLE, M_FILL, M_STREAM, M_DONE} mst_t;
    mst_t          m_st;
    logic [DW-1:0] m_buf [$];
    bit            m_pend;
    logic [DW-1:0] m_pix;
    bit            m_valid, m_uf;
    int            m_cnt;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(int n);
        for (int k = 0; k < n; k++) begin
            fifo.push_back(seq);
            seq = seq + 1'b1;
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_buf.delete(); m_pend = 0;
        m_pix = '0; m_valid = 0; m_uf = 0; m_cnt = 0;
    endtask

    task automatic check_outs(string tag);
        chk({tag, ".pixel"}, o_pixel, m_pix);
        chk({tag, ".valid"}, o_pixel_valid, m_valid);
        chk({tag, ".underflow"}, o_underflow, m_uf);
        chk({tag, ".count"}, o_pix_count, m_cnt);
        chk({tag, ".req"}, o_req, (m_st != M_IDLE));
    endtask

    task automatic do_reset();
        i_rstn = 1'b0; i_frame_start = 0; i_active = 0; i_rdata = '0;
        fifo.delete(); i_empty = 1'b1;
        model_reset();
        @(posedge i_clk); #1;
        check_outs("reset");
        chk("reset.rd", o_rd, 0);
        i_rstn = 1'b1;
    endtask

    // One pixel clock: apply inputs, check o_rd, advance model, check outputs.
    task automatic step(bit fs, bit act);
        mst_t eff, nst;
        bit   cons, rd_exp, rd_dut;
        int   base;
        i_frame_start = fs; i_active = act; i_empty = (fifo.size() == 0);
        #1;
        eff    = fs ? M_FILL : m_st;
        cons   = act && m_buf.size() > 0 && eff == M_STREAM;
        rd_exp = !i_empty && m_st != M_IDLE && (m_buf.size() + m_pend - cons) < 2;
        chk("rd", o_rd, rd_exp);
        rd_dut = o_rd;
        base   = fs ? 0 : m_cnt;
        if (fs) nst = M_FILL;
        else if (m_st == M_FILL && m_buf.size() == 2) nst = M_STREAM;
        else if (m_st == M_STREAM && act && base == FP - 1) nst = M_DONE;
        else nst = m_st;
        m_valid = act;
        m_cnt = base;
        if (act) begin
            case (eff)
                M_FILL: begin
                    m_pix = 12'hF00; m_uf = 1;
                    m_cnt = (base == FP - 1) ? 0 : base + 1;
                end
                M_STREAM: begin
                    if (cons) m_pix = m_buf[0];
                    else begin m_pix = 12'hF00; m_uf = 1; end
                    m_cnt = (base == FP - 1) ? 0 : base + 1;
                end
                M_DONE: m_pix = '0;
                default: ;
            endcase
        end
        if (cons) void'(m_buf.pop_front());
        if (m_pend) m_buf.push_back(i_rdata);
        m_pend = rd_dut;
        m_st = nst;
        @(posedge i_clk); #1;
        if (rd_dut && fifo.size() > 0) i_rdata = fifo.pop_front();
        else i_rdata = DW'($urandom);
        check_outs("step");
    endtask

    initial begin
        // Basic stream: 3 preloaded words come out in order.
        do_reset();
        push(3);
        step(1, 0);
        for (int k = 0; k < 4; k++) step(0, 0);
        step(0, 1); chk("first_pix", o_pixel, 12'h000);
        step(0, 1); chk("second_pix", o_pixel, 12'h001);
        step(0, 1); chk("third_pix", o_pixel, 12'h002);
        chk("no_underflow", o_underflow, 0);
        // Drain then underflow while FIFO empty.
        for (int k = 0; k < 3; k++) step(0, 1);
        chk("uf_color", o_pixel, 12'hF00);
        chk("uf_flag", o_underflow, 1);
        for (int k = 0; k < 3; k++) step(0, 0);
        chk("uf_sticky", o_underflow, 1);

        // Frame wrap: 20 active cycles with a constantly fed FIFO.
        do_reset();
        seq = 12'h100;
        push(4);
        step(1, 0);
        for (int k = 0; k < 4; k++) begin push(1); step(0, 0); end
        for (int k = 0; k < 20; k++) begin push(1); step(0, 1); end
        chk("wrap_count", o_pix_count, 0);
        chk("done_pix", o_pixel, 0);
        for (int k = 0; k < 4; k++) step(0, 0);

        // Mid-frame restart: buffered words retained and emitted first.
        step(1, 0);
        chk("restart_count", o_pix_count, 0);
        for (int k = 0; k < 4; k++) begin push(1); step(0, 0); end
        for (int k = 0; k < 5; k++) begin push(1); step(0, 1); end
        step(1, 0);
        chk("midframe_count", o_pix_count, 0);
        for (int k = 0; k < 3; k++) begin push(1); step(0, 0); end
        for (int k = 0; k < 4; k++) begin push(1); step(0, 1); end
        step(1, 1);
        chk("fs_active_count", o_pix_count, 1);

        // Randomized traffic.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if (fifo.size() < 8 && $urandom_range(0, 9) < 6) push(1);
            step(($urandom_range(0, 79) == 0) || k == 2, $urandom_range(0, 9) < 7);
        end

        // Asynchronous reset mid-stream.
        do_reset();
        push(8);
        step(1, 0);
        for (int k = 0; k < 4; k++) step(0, 0);
        step(0, 1); step(0, 1);
        #2 i_rstn = 1'b0;
        #1;
        chk("arst.rd", o_rd, 0);
        chk("arst.req", o_req, 0);
        chk("arst.pixel", o_pixel, 0);
        chk("arst.valid", o_pixel_valid, 0);
        chk("arst.underflow", o_underflow, 0);
        chk("arst.count", o_pix_count, 0);
        do_reset();
        push(4);
        for (int k = 0; k < 4; k++) step(0, 0);
        step(1, 0);
        for (int k = 0; k < 4; k++) step(0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
